wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter driving the register file's single write port (`reg_write_en`, `rd_addr`, `rd_write_data`). It merges two result sources:
- the in-order MEM/WB pipeline result, which cannot stall;
- the multi-cycle MUL/DIV unit result, which uses a valid/ready handshake and is buffered in a small FIFO.

It also keeps a pending-destination scoreboard so decode can stall on outstanding MUL/DIV destinations, and requests a pipeline bubble when the MUL/DIV result is starved.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `FIFO_DEPTH`, 2, MUL/DIV result buffer entries; power of two, ≥2.
- `STARVE_LIMIT`, 4, consecutive denied drain cycles before a bubble is requested; ≥1.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pipe_wb_en`  in  1  pipeline writeback valid.
- `pipe_rd`  in  5  pipeline destination.
- `pipe_data`  in  XLEN  pipeline result.
- `md_valid`  in  1  MUL/DIV result valid.
- `md_ready`  out  1  arbiter can accept a MUL/DIV result.
- `md_rd`  in  5  MUL/DIV destination.
- `md_data`  in  XLEN  MUL/DIV result.
- `issue_en`  in  1  MUL/DIV instruction dispatched this cycle.
- `issue_rd`  in  5  its destination.
- `busy_mask`  out  32  bit i set means register i has an outstanding MUL/DIV write.
- `pipe_stall`  out  1  registered bubble request to the pipeline.
- `reg_write_en`  out  1  register file write enable (registered).
- `rd_addr`  out  5  register file write address (registered).
- `rd_write_data`  out  XLEN  register file write data (registered).

## Operation
**Pipeline source**
- A pipeline write is effective when `pipe_wb_en` is high and `pipe_rd` != 0.
- An effective pipeline write always wins the slot.
- `pipe_wb_en` with `pipe_rd` == 0 is not an effective write: it produces no register file write and leaves the slot free.

**MUL/DIV source and FIFO**
- Accept on `md_valid && md_ready`.
- `md_ready` = (count < `FIFO_DEPTH`), derived combinationally from registered count only; it does not depend on a same-cycle pop.
- An accepted result with `md_rd` == 0 is discarded and never enters the FIFO.
- Read and write pointers wrap modulo `FIFO_DEPTH`.
- Simultaneous push and pop leaves count unchanged.

**Slot arbitration (one output write per cycle)**
- Effective pipeline write present: load the output registers from the pipe fields and set `reg_write_en`=1.
- Otherwise, FIFO non-empty: pop the head, load the output registers from it, and set `reg_write_en`=1.
- Otherwise: `reg_write_en`=0; `rd_addr` and `rd_write_data` hold their previous values.

**Scoreboard (`busy_mask`)**
- `issue_en` with `issue_rd` != 0 sets bit `issue_rd`.
- A FIFO pop clears bit `rd_addr` of the popped entry.
- Set and clear of the same bit in the same cycle: set wins.
- Bit 0 is always 0.
- Decode stalls any instruction that reads or writes a busy register. This prevents WAW/RAW between the two sources; the arbiter does not reorder or check for this.

**Starvation**
- `starve_cnt` increments each cycle the FIFO is non-empty and the head is denied by an effective pipeline write.
- `starve_cnt` resets to 0 on any pop or when the FIFO is empty.
- When `starve_cnt` reaches `STARVE_LIMIT`, `pipe_stall` is set on that edge.
- `pipe_stall` stays high until the edge on which the FIFO pops, and clears on that edge.
- The pipeline guarantees `pipe_wb_en`=0 on the cycle after it sees `pipe_stall`=1.

## Timing
- **Pipeline write:** inputs in cycle N, `reg_write_en`/`rd_addr`/`rd_write_data` valid in cycle N+1. Latency 1.
- **MUL/DIV write:** handshake in cycle N, entry in FIFO at the edge ending N. Earliest pop is at the edge ending N+1, so the output is valid in N+2. Minimum latency is 2; there is no bypass.
- **`busy_mask` clear:** the bit clears in the same cycle `reg_write_en` shows the MUL/DIV write.
- **Reset (`rst` low, asynchronous):**
  - `reg_write_en`=0, `rd_addr`=0, `rd_write_data`=0.
  - `busy_mask`=0, `pipe_stall`=0, FIFO empty, `starve_cnt`=0.
  - `md_ready` is 1 once reset deasserts.
  - Reset mid-operation drops all buffered results and busy bits; upstream flushes concurrently.
- **Full FIFO:** `md_ready`=0 even if a pop happens that cycle; acceptance resumes the next cycle.

## Structure
- Shared package `wb_pkg`:
  - `REG_ADDR_W`=5.
  - `wb_entry_t` struct: rd[4:0], data[XLEN-1:0].
  - Default `XLEN`.
- One sub-module, `wb_fifo`:
  - Synchronous FIFO of `wb_entry_t`, with push/pop/full/empty/count.
  - Asynchronous active-low reset on `rst`.
- Arbitration, scoreboard and starvation counter live in `wb_arbiter`.

## Test plan
1. **Pipeline write:** `pipe_wb_en`=1, `pipe_rd`=5, `pipe_data`=0xDEADBEEF in cycle 0 → cycle 1: `reg_write_en`=1, `rd_addr`=5, `rd_write_data`=0xDEADBEEF. Same stimulus with `pipe_rd`=0 → `reg_write_en`=0.
2. **Scoreboard and MUL/DIV path:**
   - `issue_en`, `issue_rd`=7 → `busy_mask`[7]=1 next cycle.
   - Then `md_valid`, `md_rd`=7, `md_data`=0x12345678 with pipe idle → write to x7 visible 2 cycles after the handshake, and `busy_mask`[7]=0 in that same cycle.
3. **Collision:** MUL/DIV entry (rd=3) queued and pipe writing rd=4 for 3 consecutive cycles → x4 written 3 times, then x3 written on the first free cycle.
4. **Full FIFO:** depth 2, hold the pipe busy, offer 3 MUL/DIV results → `md_ready`=0 after 2 accepts; the third is accepted only after a pop.
5. **Starvation:** `STARVE_LIMIT`=4, FIFO non-empty, pipe writing every cycle → `pipe_stall`=1 after the 4th denied cycle. The next cycle pipe is idle, the FIFO pops, and `pipe_stall` deasserts.
6. **Reset mid-operation:** assert `rst`=0 asynchronously with 2 queued entries and `busy_mask`=0x00000088 → all outputs 0 immediately, FIFO empty, `md_ready`=1 after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its result FIFO.
package wb_pkg;

    // Default data width; wb_arbiter's XLEN parameter must match it because
    // the FIFO entry type below is sized from it.
    localparam int XLEN_DEFAULT = 32;

    // Register file address width (32 architectural registers).
    localparam int REG_ADDR_W = 5;

    // One buffered MUL/DIV result: destination register and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries. DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  wb_entry_t                din_i,
    input  logic                     pop_i,
    output wb_entry_t                dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Overflow/underflow requests are ignored rather than corrupting state.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Next pointer and occupancy values; push and pop together keep count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the non-stallable pipeline result and buffered
// MUL/DIV results onto the single register file write port, tracks
// outstanding MUL/DIV destinations, and asks the pipeline for a bubble when
// the MUL/DIV head has been starved too long.
//
// Handshake: a MUL/DIV result transfers on a rising edge where md_valid and
// md_ready are both high; md_ready depends only on the registered FIFO count,
// so it never reflects a pop happening in the same cycle.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_wb_en,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [XLEN-1:0]       md_data,
    input  logic                  issue_en,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic [31:0]           busy_mask,
    output logic                  pipe_stall,
    output logic                  reg_write_en,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_write_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic                  pipe_eff;
    logic                  md_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    wb_entry_t             push_entry;
    wb_entry_t             head_entry;

    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [31:0]           busy_q, busy_d;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic                  stall_q, stall_d;

    // Writes to x0 are architecturally void on both sources.
    assign pipe_eff = pipe_wb_en && (pipe_rd != '0);

    // full is a decode of the registered count, so md_ready is too.
    assign md_ready   = !fifo_full;
    assign md_push    = md_valid && md_ready && (md_rd != '0);
    assign push_entry = '{rd: md_rd, data: md_data};

    // The buffered head drains only on slots the pipeline leaves free.
    assign fifo_pop = !pipe_eff && !fifo_empty;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (md_push),
        .din_i   (push_entry),
        .pop_i   (fifo_pop),
        .dout_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Slot arbitration: pipeline first, then FIFO head; idle holds addr/data.
    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (pipe_eff) begin
            we_d   = 1'b1;
            addr_d = pipe_rd;
            data_d = pipe_data;
        end else if (fifo_pop) begin
            we_d   = 1'b1;
            addr_d = head_entry.rd;
            data_d = head_entry.data;
        end
    end

    // Pending-destination scoreboard; a same-cycle set overrides the clear.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) begin
            busy_d[head_entry.rd] = 1'b0;
        end
        if (issue_en && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Starvation tracking and the sticky bubble request it raises.
    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (fifo_pop || (fifo_count == '0)) begin
            starve_d = '0;
        end else if (pipe_eff && (starve_q < STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end
        if (fifo_pop) begin
            stall_d = 1'b0;
        end else if (starve_d == STV_W'(STARVE_LIMIT)) begin
            stall_d = 1'b1;
        end
    end

    // All arbiter state; reset drops every pending write and busy bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign reg_write_en  = we_q;
    assign rd_addr       = addr_q;
    assign rd_write_data = data_q;
    assign busy_mask     = busy_q;
    assign pipe_stall    = stall_q;

endmodule
